bitty_instr_sequencer: RTL and testbench
========================================

// Module: bitty_instr_sequencer
// PURPOSE
//  Issuing end of the Bitty run/done handshake. Holds a small program RAM, loaded over a write
//  port, and drives instruction+run into the Bitty core one word at a time. Waits for the core's
//  done, then advances the PC until the programmed length is exhausted. Flags a hung core
//  through a per-instruction timeout. Sits beside the core top; its outputs feed instruction/run.
// PARAMETERS
//  DEPTH    16   program RAM words (power of two)
//  AW       4    address width = log2(DEPTH)
//  IW       16   instruction width
//  TIMEOUT  255  max cycles in WAIT before error (>=1)
// PORTS
//  clk          in   1    rising-edge clock
//  reset        in   1    asynchronous, active-low reset
//  load_en      in   1    write load_data to RAM[load_addr] (ignored while busy)
//  load_addr    in   AW   RAM write address
//  load_data    in   IW   RAM write data
//  start        in   1    begin executing RAM[0..prog_len-1] (ignored while busy)
//  prog_len     in   AW+1 instruction count, 0..DEPTH, sampled on accepted start
//  done         in   1    core completion pulse
//  instruction  out  IW   word presented to the core
//  run          out  1    one-cycle issue strobe
//  pc           out  AW   index of current instruction
//  busy         out  1    high in ISSUE/WAIT
//  finished     out  1    one-cycle pulse when program completes normally
//  instr_count  out  AW+1 instructions completed since last accepted start
//  timeout_err  out  1    sticky; core failed to assert done within TIMEOUT cycles
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE; instruction, run, pc, busy, finished, instr_count,
//   timeout_err, wait counter all 0. RAM contents not reset. Reset mid-run aborts at once.
//  States: IDLE, ISSUE, WAIT, ERR.
//  IDLE: load_en writes RAM on clk edge. Accepted start latches len=prog_len, clears pc,
//   instr_count, timeout_err. If len==0 -> finished pulses next cycle, stay IDLE.
//   Otherwise -> ISSUE.
//  ISSUE (1 cycle): instruction<=RAM[pc] registered on entry; run=1 this cycle only;
//   wait counter cleared; -> WAIT. done during ISSUE is ignored (no same-cycle completion).
//  WAIT: run=0; instruction held stable. done=1 -> instr_count+1.
//   If pc==len-1 -> finished pulse, IDLE (pc holds last index). Else pc+1, ISSUE.
//   done=0 -> counter+1. Counter reaching TIMEOUT -> timeout_err=1, ERR.
//  ERR: busy=0, run=0; only an accepted start (clears timeout_err) or reset exits.
//  Issue cadence: min 2 cycles per instruction (ISSUE+1 WAIT cycle with done).
//  start/load_en asserted while busy: no effect; load_en and start together in IDLE: write occurs,
//   start uses new RAM contents (first fetch is in ISSUE, one cycle later).
//  prog_len>DEPTH is saturated to DEPTH. pc never wraps; instr_count never exceeds len.
//  busy is combinational from state (ISSUE|WAIT); all other outputs are registered.
// TESTING
//  1 Reset with reset=0 mid-WAIT -> all outputs 0 on same edge, state IDLE, RAM intact.
//  2 Load 3 words {0x1234,0x0042,0xBEEF}, start len=3, done 2 cycles after each run -> three
//    single-cycle run pulses with matching instruction; finished once; instr_count=3; pc=2.
//  3 start with prog_len=0 -> no run; finished pulses one cycle later; instr_count=0.
//  4 Never assert done, TIMEOUT=255 -> timeout_err=1 after 255 WAIT cycles; busy=0; restart
//    with start clears it and reissues RAM[0].
//  5 done held high through ISSUE, or start/load_en pulsed while busy -> no early completion,
//    no RAM change, sequence unaffected.
//  6 prog_len=DEPTH=16, done every WAIT cycle -> 16 instructions at 2-cycle cadence; pc=15.

Source files
------------

// File: rtl/bitty_instr_sequencer.sv
// Issuing side of the Bitty run/done handshake: a small program RAM is stepped through one word
// at a time, waiting for the core's done between words and flagging a core that never answers.
module bitty_instr_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int IW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          done,
  output logic [IW-1:0] instruction,
  output logic          run,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          finished,
  output logic [AW:0]   instr_count,
  output logic          timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] TIMEOUT_L = CW'(TIMEOUT);

  logic [IW-1:0] mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          run_q, run_d;
  logic          fin_q, fin_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic [CW-1:0] wcnt_q, wcnt_d;

  logic          idle_like;
  logic          start_ok;
  logic          load_ok;
  logic [AW:0]   len_sat;
  logic          last_instr;

  assign idle_like  = (state_q == S_IDLE) || (state_q == S_ERR);
  assign start_ok   = start && idle_like;
  assign load_ok    = load_en && idle_like;
  assign len_sat    = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign last_instr = ({1'b0, pc_q} == (len_q - 1'b1));

  // NOTE: storage array has no reset branch so it can map onto RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_ok) mem[load_addr] <= load_data;
  end

  always_comb begin
    // NOTE: every target gets a default first so no path can leave it unassigned (no latches).
    state_d = state_q;
    len_d   = len_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    run_d   = 1'b0;
    fin_d   = 1'b0;
    count_d = count_q;
    err_d   = err_q;
    wcnt_d  = wcnt_q;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start_ok) begin
          len_d   = len_sat;
          pc_d    = '0;
          count_d = '0;
          err_d   = 1'b0;
          wcnt_d  = '0;
          if (len_sat == '0) begin
            fin_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      // Fetch happens here, so a word written alongside start is the one issued.
      S_ISSUE: begin
        instr_d = mem[pc_q];
        run_d   = 1'b1;
        wcnt_d  = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (done) begin
          count_d = count_q + 1'b1;
          if (last_instr) begin
            fin_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_ISSUE;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_d == TIMEOUT_L) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      run_q   <= 1'b0;
      fin_q   <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      run_q   <= run_d;
      fin_q   <= fin_d;
      count_q <= count_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign instruction = instr_q;
  assign run         = run_q;
  assign pc          = pc_q;
  assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign finished    = fin_q;
  assign instr_count = count_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_bitty_instr_sequencer.sv
// Bench for bitty_instr_sequencer: a transaction-level program model (array of words plus
// expected issue order) checked against run/instruction/finished at every handshake step.
module tb_bitty_instr_sequencer;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int IW      = 16;
  localparam int TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [IW-1:0] load_data;
  logic          start;
  logic [AW:0]   prog_len;
  logic          done;
  logic [IW-1:0] instruction;
  logic          run;
  logic [AW-1:0] pc;
  logic          busy;
  logic          finished;
  logic [AW:0]   instr_count;
  logic          timeout_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [IW-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  bitty_instr_sequencer #(
    .DEPTH(DEPTH), .AW(AW), .IW(IW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .prog_len(prog_len), .done(done),
    .instruction(instruction), .run(run), .pc(pc), .busy(busy),
    .finished(finished), .instr_count(instr_count), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_word(input logic [AW-1:0] addr, input logic [IW-1:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    tick();
    load_en = 1'b0;
    ref_mem[addr] = data;
  endtask

  // Runs one program of n words against the model; done comes min_d..max_d cycles after run.
  task automatic run_program(input int n, input int min_d, input int max_d, input bit hold_done,
                             input bit poke_busy, input bit load_with_start,
                             input logic [IW-1:0] start_word);
    int l;
    l = (n > DEPTH) ? DEPTH : n;
    if (load_with_start) begin
      load_en   = 1'b1;
      load_addr = '0;
      load_data = start_word;
      ref_mem[0] = start_word;
    end
    start    = 1'b1;
    prog_len = n[AW:0];
    done     = hold_done;
    tick();
    start   = 1'b0;
    load_en = 1'b0;
    check("start_err_clear", timeout_err, 0);
    check("start_count_clear", instr_count, 0);
    if (l == 0) begin
      check("len0_finished", finished, 1);
      check("len0_no_run", run, 0);
      check("len0_not_busy", busy, 0);
      tick();
      check("len0_pulse_end", finished, 0);
      check("len0_no_run_late", run, 0);
      return;
    end
    check("start_busy", busy, 1);
    for (int i = 0; i < l; i++) begin
      int waited;
      int d;
      logic [IW-1:0] held;
      waited = 0;
      check("issue_no_run", run, 0);
      do begin
        tick();
        waited++;
      end while (run !== 1'b1 && waited < 4);
      check("run_latency", waited, 1);
      if (run !== 1'b1) return;
      check("instr_word", instruction, ref_mem[i]);
      check("instr_pc", pc, i);
      held = instruction;
      d = hold_done ? 0 : int'($urandom_range(max_d, min_d));
      for (int k = 0; k < d; k++) begin
        done = 1'b0;
        if (poke_busy) begin
          start     = 1'b1;
          prog_len  = (AW + 1)'($urandom_range(31, 0));
          load_en   = 1'b1;
          load_addr = AW'($urandom_range(DEPTH - 1, 0));
          load_data = IW'($urandom);
        end
        tick();
        start   = 1'b0;
        load_en = 1'b0;
        check("run_one_cycle", run, 0);
        check("instr_stable", instruction, held);
        check("wait_busy", busy, 1);
      end
      done = 1'b1;
      tick();
      if (!hold_done) done = 1'b0;
      if (i == l - 1) begin
        check("end_finished", finished, 1);
        check("end_count", instr_count, l);
        check("end_pc", pc, l - 1);
        check("end_not_busy", busy, 0);
      end else begin
        check("mid_not_finished", finished, 0);
        check("mid_count", instr_count, i + 1);
        check("mid_busy", busy, 1);
      end
    end
    done = 1'b0;
    tick();
    check("finish_pulse_end", finished, 0);
    check("idle_no_run", run, 0);
  endtask

  initial begin
    reset     = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    start     = 1'b0;
    prog_len  = '0;
    done      = 1'b0;
    #1 reset = 1'b0;
    #2;
    check("rst_instruction", instruction, 0);
    check("rst_run", run, 0);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_finished", finished, 0);
    check("rst_count", instr_count, 0);
    check("rst_timeout", timeout_err, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    for (int a = 0; a < DEPTH; a++) load_word(AW'(a), IW'($urandom));

    // Three-word directed program, done two cycles after each run.
    load_word(4'd0, 16'h1234);
    load_word(4'd1, 16'h0042);
    load_word(4'd2, 16'hBEEF);
    run_program(3, 1, 1, 1'b0, 1'b0, 1'b0, '0);

    // Empty program and over-long program saturating to DEPTH.
    run_program(0, 0, 0, 1'b0, 1'b0, 1'b0, '0);
    run_program(20, 0, 0, 1'b0, 1'b0, 1'b0, '0);

    // Full depth at the two-cycle cadence, then with done held high through every ISSUE.
    run_program(DEPTH, 0, 0, 1'b0, 1'b0, 1'b0, '0);
    run_program(DEPTH, 0, 0, 1'b1, 1'b0, 1'b0, '0);

    // Start/load pokes while busy must not disturb the program or the RAM.
    run_program(6, 1, 3, 1'b0, 1'b1, 1'b0, '0);
    run_program(DEPTH, 0, 0, 1'b0, 1'b0, 1'b0, '0);

    // Write and start in the same cycle: the new word is issued first.
    run_program(2, 0, 1, 1'b0, 1'b0, 1'b1, 16'hA5C3);

    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(1, 0) == 1) load_word(AW'($urandom_range(DEPTH - 1, 0)), IW'($urandom));
      run_program(int'($urandom_range(DEPTH, 1)), 0, 3, 1'b0, r[0], 1'b0, '0);
    end

    // Hung core: no done ever.
    start    = 1'b1;
    prog_len = 5'd2;
    tick();
    start = 1'b0;
    tick();
    check("to_run_seen", run, 1);
    check("to_instr", instruction, ref_mem[0]);
    for (int k = 0; k < TIMEOUT - 1; k++) tick();
    check("to_not_yet_err", timeout_err, 0);
    check("to_still_busy", busy, 1);
    tick();
    check("to_err_set", timeout_err, 1);
    check("to_err_not_busy", busy, 0);
    check("to_err_no_run", run, 0);
    repeat (3) tick();
    check("to_err_sticky", timeout_err, 1);
    run_program(3, 0, 2, 1'b0, 1'b0, 1'b0, '0);

    // Asynchronous reset in the middle of WAIT, then confirm the RAM survived.
    start    = 1'b1;
    prog_len = 5'd5;
    tick();
    start = 1'b0;
    repeat (2) tick();
    check("mr_in_wait", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("mr_instruction", instruction, 0);
    check("mr_run", run, 0);
    check("mr_pc", pc, 0);
    check("mr_busy", busy, 0);
    check("mr_finished", finished, 0);
    check("mr_count", instr_count, 0);
    check("mr_timeout", timeout_err, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    run_program(DEPTH, 0, 1, 1'b0, 1'b0, 1'b0, '0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
